// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use stalls, multiply/divide occupancy
// interlock on HI/LO, and wrong-path IF/ID flush on a taken branch.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_md,
    input  logic       id_md_div,
    input  logic       id_reads_hilo,
    input  logic       ex_mem_rd,
    input  logic [4:0] ex_dest,
    input  logic       ex_branch_taken,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic {IDLE, MD_RUN} state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;
    logic             busy_int;
    logic             done_int;
    logic             md_stall;
    logic             issue;

    assign load_use = ex_mem_rd && (ex_dest != 5'd0) &&
                      ((id_uses_rs && (ex_dest == id_rs)) ||
                       (id_uses_rt && (ex_dest == id_rt)));

    assign busy_int = (state == MD_RUN);
    assign done_int = busy_int && (cnt == '0);
    assign md_stall = busy_int && !done_int && (id_is_md || id_reads_hilo);

    // A new op may start in the cycle the previous one completes, so the
    // unit stays occupied with no idle gap between back-to-back ops.
    assign issue = id_is_md && !load_use && !ex_branch_taken &&
                   ((state == IDLE) || done_int);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (issue) begin
            state_nxt = MD_RUN;
            cnt_nxt   = id_md_div ? DIV_LOAD : MUL_LOAD;
        end else if (state == MD_RUN) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // A running MD op is older than the branch, so flush never touches it.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (!rst) begin
            md_busy = busy_int;
            md_done = done_int;
            if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use || md_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default latencies plus a MUL_LAT=1 instance.
// Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, md_busy, md_done}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_uses_rs, id_uses_rt, id_is_md, id_md_div, id_reads_hilo;
    logic       ex_mem_rd, ex_branch_taken;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, md_busy, md_done;
    logic       pc_stall1, if_id_stall1, if_id_flush1, id_ex_bubble1, md_busy1, md_done1;
    logic [5:0] outs, outs1;
    int         n_checks = 0;
    int         n_errors = 0;

    assign outs  = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, md_busy, md_done};
    assign outs1 = {pc_stall1, if_id_stall1, if_id_flush1, id_ex_bubble1, md_busy1, md_done1};

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_md(id_is_md),
        .id_md_div(id_md_div), .id_reads_hilo(id_reads_hilo), .ex_mem_rd(ex_mem_rd),
        .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .md_busy(md_busy), .md_done(md_done)
    );

    hazard_ctrl #(.MUL_LAT(1), .DIV_LAT(32), .CNT_W(6)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_md(id_is_md),
        .id_md_div(id_md_div), .id_reads_hilo(id_reads_hilo), .ex_mem_rd(ex_mem_rd),
        .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall1), .if_id_stall(if_id_stall1), .if_id_flush(if_id_flush1),
        .id_ex_bubble(id_ex_bubble1), .md_busy(md_busy1), .md_done(md_done1)
    );

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_dest = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_md = 1'b0; id_md_div = 1'b0;
        id_reads_hilo = 1'b0; ex_mem_rd = 1'b0; ex_branch_taken = 1'b0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        ex_mem_rd = 1'b1; ex_dest = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        id_is_md = 1'b1; ex_branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL reset_forced_zero: got %b exp %b", outs, 6'b000000);
        end
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL reset_idle: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        ex_mem_rd = 1'b1; ex_dest = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b110100) begin
            n_errors++; $display("FAIL load_use_rs: got %b exp %b", outs, 6'b110100);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL load_use_one_cycle: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
        ex_mem_rd = 1'b1; ex_dest = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        id_rt = 5'd0; id_uses_rt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL load_use_r0: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
        clear_inputs();
        ex_mem_rd = 1'b1; ex_dest = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b110100) begin
            n_errors++; $display("FAIL load_use_rt: got %b exp %b", outs, 6'b110100);
        end
        next_cycle();
        id_uses_rt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL load_use_rt_unused: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
        clear_inputs();
        ex_dest = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL load_use_not_load: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mult();
        id_is_md = 1'b1; id_md_div = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL mult_issue_cycle: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
        clear_inputs();
        id_reads_hilo = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 6'b110110) begin
                n_errors++; $display("FAIL mult_mfhi_stall[%0d]: got %b exp %b", k, outs, 6'b110110);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000011) begin
            n_errors++; $display("FAIL mult_done_release: got %b exp %b", outs, 6'b000011);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL mult_back_idle: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        id_is_md = 1'b1; id_md_div = 1'b1;
        next_cycle();
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 6'b110110) begin
                n_errors++; $display("FAIL div_second_stall[%0d]: got %b exp %b", k, outs, 6'b110110);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000011) begin
            n_errors++; $display("FAIL div_first_done: got %b exp %b", outs, 6'b000011);
        end
        next_cycle();
        clear_inputs();
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 6'b000010) begin
                n_errors++; $display("FAIL div_second_busy[%0d]: got %b exp %b", k, outs, 6'b000010);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000011) begin
            n_errors++; $display("FAIL div_second_done: got %b exp %b", outs, 6'b000011);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL div_second_idle: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
    endtask

    task automatic test_branch_flush();
        ex_branch_taken = 1'b1; ex_mem_rd = 1'b1; ex_dest = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
        id_is_md = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b001100) begin
            n_errors++; $display("FAIL flush_priority: got %b exp %b", outs, 6'b001100);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL flush_no_issue: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
        id_is_md = 1'b1;
        next_cycle();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b001110) begin
            n_errors++; $display("FAIL flush_during_run: got %b exp %b", outs, 6'b001110);
        end
        next_cycle();
        clear_inputs();
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 6'b000010) begin
                n_errors++; $display("FAIL flush_run_busy[%0d]: got %b exp %b", k, outs, 6'b000010);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000011) begin
            n_errors++; $display("FAIL flush_run_done: got %b exp %b", outs, 6'b000011);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_run();
        id_is_md = 1'b1; id_md_div = 1'b1;
        next_cycle();
        clear_inputs();
        for (int k = 1; k <= 24; k++) next_cycle();
        rst = 1'b1;
        id_reads_hilo = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== 6'b000000) begin
            n_errors++; $display("FAIL rst_mid_run_forced: got %b exp %b", outs, 6'b000000);
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 6'b000000) begin
                n_errors++; $display("FAIL rst_abandon[%0d]: got %b exp %b", k, outs, 6'b000000);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_mul_lat1();
        do_reset();
        id_is_md = 1'b1; id_md_div = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs1 !== 6'b000000) begin
            n_errors++; $display("FAIL lat1_issue: got %b exp %b", outs1, 6'b000000);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (outs1 !== 6'b000011) begin
            n_errors++; $display("FAIL lat1_done: got %b exp %b", outs1, 6'b000011);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (outs1 !== 6'b000000) begin
            n_errors++; $display("FAIL lat1_idle: got %b exp %b", outs1, 6'b000000);
        end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mult();
        test_back_to_back();
        test_branch_flush();
        do_reset();
        test_reset_mid_run();
        test_mul_lat1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock controller; the companion to the forwarding unit.
- Handles the hazards that forwarding cannot resolve:
  - load-use: stall one cycle and bubble EX;
  - multi-cycle mult/div occupancy (HI/LO interlock), tracked by an internal FSM and counter;
  - taken-branch flush of the wrong-path IF/ID instruction.
- Sits beside the ID stage and drives the PC, IF/ID and ID/EX register controls.

Parameters:
- MUL_LAT, 4, cycles a mult occupies the MD unit (must be ≥1).
- DIV_LAT, 32, cycles a div occupies the MD unit (must be ≥1).
- CNT_W, 6, counter width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_rs  input  5  rs of the instruction in ID.
- id_rt  input  5  rt of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_is_md  input  1  ID instruction is mult/div.
- id_md_div  input  1  qualifies id_is_md: 1=div, 0=mult.
- id_reads_hilo  input  1  ID instruction is mfhi/mflo.
- ex_mem_rd  input  1  EX instruction is a load.
- ex_dest  input  5  destination register of the EX instruction.
- ex_branch_taken  input  1  branch/jump in EX resolved taken.
- pc_stall  output  1  hold PC.
- if_id_stall  output  1  hold the IF/ID register.
- if_id_flush  output  1  clear the IF/ID register to NOP.
- id_ex_bubble  output  1  load NOP into ID/EX.
- md_busy  output  1  MD unit occupied.
- md_done  output  1  one-cycle pulse when the MD result is valid.

Behaviour:
- State: IDLE, MD_RUN; counter cnt[CNT_W-1:0].
- Reset: state=IDLE, cnt=0.
  - While rst=1, all outputs are forced 0.
  - rst mid-MD_RUN abandons the op; no md_done is generated.
- load_use = ex_mem_rd & (ex_dest!=0) & ((id_uses_rs & ex_dest==id_rs) | (id_uses_rt & ex_dest==id_rt)).
- md_busy = (state==MD_RUN).
- md_done = (state==MD_RUN) & (cnt==0).
- md_stall = md_busy & ~md_done & (id_is_md | id_reads_hilo).
- issue = id_is_md & ~load_use & ~ex_branch_taken & (state==IDLE | md_done).
- Transitions:
  - On issue: state goes to MD_RUN and cnt is loaded with (id_md_div ? DIV_LAT : MUL_LAT)-1.
  - MD_RUN with cnt!=0: cnt decrements.
  - MD_RUN with cnt==0 and no issue: state returns to IDLE.
  - Back-to-back issue in the md_done cycle reloads the counter and stays in MD_RUN.
- Timing: an op issued in cycle N is in MD_RUN for cycles N+1..N+LAT; md_done=1 at N+LAT.
  - An mfhi/mflo waiting in ID proceeds in the md_done cycle; the result is forwarded then.
- Output priority, highest first:
  1. ex_branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0. The ID instruction is wrong-path and is never issued.
  2. load_use | md_stall: pc_stall=1, if_id_stall=1, id_ex_bubble=1, if_id_flush=0.
  3. Otherwise: all four controls are 0.
- An MD op already in MD_RUN is older than any branch in EX; a flush never cancels it.
- Register $0 never causes a load-use stall.
- Load-use and md_stall together produce a single stall; the second hazard is re-evaluated next cycle.
- Outputs are combinational from state and inputs; no added latency.

Test Plan:
- Load-use: ex_mem_rd=1, ex_dest=5, id_rs=5, id_uses_rs=1 → pc_stall = if_id_stall = id_ex_bubble = 1 for that cycle only. With ex_dest=0 → all 0.
- Mult issue, MUL_LAT=4, id_is_md=1, id_md_div=0 at cycle 10:
  - md_busy=1 on cycles 11-14; md_done=1 only on cycle 14; IDLE at 15.
  - mfhi held in ID on cycles 11-13 stalls; it releases on cycle 14.
- Div, DIV_LAT=32: md_done is exactly 32 cycles after issue.
  - A second div in ID stalls until the md_done cycle, then issues. md_busy stays 1 with no gap, and the new md_done comes 32 cycles later.
- Branch flush: ex_branch_taken=1 while load_use=1 and id_is_md=1 in IDLE → if_id_flush=1, id_ex_bubble=1, stalls 0, no issue (md_busy stays 0 next cycle).
- rst=1 at MD_RUN with cnt=7 → next cycle md_busy=0, no md_done pulse. While rst=1 all outputs are 0.
- MUL_LAT=1 edge case: issue at N → md_busy=1 and md_done=1 at N+1 only.
